// File: rtl/occupancy_counter.sv
// rtl/occupancy_counter.sv - debounced saturating up/down occupancy counter
// Two identical sync/debounce/rising-edge channels feed a 0..MAX_COUNT counter.
module occupancy_counter #(
  parameter int MAX_COUNT       = 81,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc_raw,
  input  logic       dec_raw,
  input  logic       clr,
  output logic [7:0] count,
  output logic       full,
  output logic       empty,
  output logic       reject
);

  localparam logic [19:0] DB_LAST = 20'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]  MAX_VAL = 8'(MAX_COUNT);

  logic [1:0] w_raw;
  logic [1:0] w_ev;
  logic [7:0] r_count;
  logic       r_reject;

  assign w_raw = {dec_raw, inc_raw};

  // Channel 0 is increment, channel 1 is decrement.
  for (genvar g = 0; g < 2; g++) begin : g_chan
    logic        r_s1;
    logic        r_s2;
    logic        r_acc;
    logic        r_acc_d;
    logic [19:0] r_db_cnt;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_s1     <= 1'b0;
        r_s2     <= 1'b0;
        r_acc    <= 1'b0;
        r_acc_d  <= 1'b0;
        r_db_cnt <= '0;
      end else begin
        r_s1    <= w_raw[g];
        r_s2    <= r_s1;
        r_acc_d <= r_acc;
        if (r_s2 == r_acc) begin
          r_db_cnt <= '0;
        end else if (r_db_cnt == DB_LAST) begin
          r_acc    <= r_s2;
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + 20'd1;
        end
      end
    end

    assign w_ev[g] = r_acc & ~r_acc_d;
  end

  // Simultaneous inc/dec events cancel; clr discards both.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count  <= '0;
      r_reject <= 1'b0;
    end else begin
      r_reject <= 1'b0;
      if (clr) begin
        r_count <= '0;
      end else if (w_ev[0] && !w_ev[1]) begin
        if (r_count < MAX_VAL) r_count <= r_count + 8'd1;
        else                   r_reject <= 1'b1;
      end else if (w_ev[1] && !w_ev[0]) begin
        if (r_count > 8'd0) r_count <= r_count - 8'd1;
        else                r_reject <= 1'b1;
      end
    end
  end

  assign count  = r_count;
  assign reject = r_reject;
  assign full   = (r_count == MAX_VAL);
  assign empty  = (r_count == 8'd0);

endmodule

// File: tb/tb_occupancy_counter.sv
// tb/tb_occupancy_counter.sv - self-checking bench for occupancy_counter
// Reference model: a level is accepted once the last D synchronized samples all disagree with it.
module tb_occupancy_counter;

  localparam int D    = 4;
  localparam int MAXC = 81;
  localparam int LAT  = 7;

  logic       clk;
  logic       rst;
  logic       inc_raw;
  logic       dec_raw;
  logic       clr;
  logic [7:0] count;
  logic       full;
  logic       empty;
  logic       reject;

  int compared;
  int mismatched;

  int m_count;
  bit m_reject;
  bit m_acc [2];
  bit m_ev [2];
  bit hist [2][D+2];

  occupancy_counter #(.MAX_COUNT(MAXC), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .inc_raw(inc_raw), .dec_raw(dec_raw), .clr(clr),
    .count(count), .full(full), .empty(empty), .reject(reject)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_count  = 0;
    m_reject = 1'b0;
    for (int c = 0; c < 2; c++) begin
      m_acc[c] = 1'b0;
      m_ev[c]  = 1'b0;
      for (int k = 0; k < D + 2; k++) hist[c][k] = 1'b0;
    end
  endtask

  task automatic model_edge();
    bit raw [2];
    bit all_diff;
    int nc;
    if (rst) begin
      model_reset();
      return;
    end
    raw[0] = inc_raw;
    raw[1] = dec_raw;
    nc = m_count;
    m_reject = 1'b0;
    if (clr) nc = 0;
    else if (m_ev[0] && !m_ev[1]) begin
      if (m_count < MAXC) nc = m_count + 1; else m_reject = 1'b1;
    end else if (m_ev[1] && !m_ev[0]) begin
      if (m_count > 0) nc = m_count - 1; else m_reject = 1'b1;
    end
    m_count = nc;
    for (int c = 0; c < 2; c++) begin
      for (int k = D + 1; k > 0; k--) hist[c][k] = hist[c][k-1];
      hist[c][0] = raw[c];
      all_diff = 1'b1;
      for (int k = 2; k <= D + 1; k++) if (hist[c][k] == m_acc[c]) all_diff = 1'b0;
      m_ev[c] = 1'b0;
      if (all_diff) begin
        m_acc[c] = ~m_acc[c];
        m_ev[c]  = m_acc[c];
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic press(input int which, input int hi, input int lo, output int rej);
    rej = 0;
    if (which == 0) inc_raw = 1'b1; else dec_raw = 1'b1;
    repeat (hi) begin tick(); if (reject) rej++; end
    inc_raw = 1'b0;
    dec_raw = 1'b0;
    repeat (lo) begin tick(); if (reject) rej++; end
  endtask

  task automatic do_clear();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    compared += 4;
    if (count !== 8'd0) begin mismatched++; $display("FAIL reset_count: got %0d want 0", count); end
    if (full !== 1'b0) begin mismatched++; $display("FAIL reset_full: got %b want 0", full); end
    if (empty !== 1'b1) begin mismatched++; $display("FAIL reset_empty: got %b want 1", empty); end
    if (reject !== 1'b0) begin mismatched++; $display("FAIL reset_reject: got %b want 0", reject); end
    rst = 1'b0;
  endtask

  task automatic test_single_press();
    int exp;
    inc_raw = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      exp = (i >= LAT) ? 1 : 0;
      compared++;
      if (count !== 8'(exp)) begin mismatched++; $display("FAIL single_press edge %0d: count=%0d want %0d", i, count, exp); end
      if (i == LAT) begin
        compared++;
        if (empty !== 1'b0) begin mismatched++; $display("FAIL single_press_empty: got %b want 0", empty); end
      end
    end
    inc_raw = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      compared++;
      if (count !== 8'd1 || reject !== 1'b0) begin
        mismatched++;
        $display("FAIL single_release edge %0d: count=%0d reject=%b want 1/0", i, count, reject);
      end
    end
  endtask

  task automatic test_bounce();
    bit pat [9];
    int base;
    int exp;
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    base = m_count;
    for (int k = 0; k < 30; k++) begin
      inc_raw = (k < 9) ? pat[k] : 1'b1;
      tick();
      exp = base + ((k + 1 >= 12) ? 1 : 0);
      compared++;
      if (count !== 8'(exp)) begin mismatched++; $display("FAIL bounce edge %0d: count=%0d want %0d", k + 1, count, exp); end
    end
    inc_raw = 1'b0;
    repeat (15) tick();
    compared++;
    if (count !== 8'(base + 1)) begin mismatched++; $display("FAIL bounce_final: count=%0d want %0d", count, base + 1); end
  endtask

  task automatic test_saturation();
    int rej;
    int total_rej;
    do_clear();
    total_rej = 0;
    for (int p = 0; p < MAXC; p++) begin
      press(0, 8, 8, rej);
      total_rej += rej;
    end
    compared += 3;
    if (count !== 8'(MAXC)) begin mismatched++; $display("FAIL sat_count: got %0d want %0d", count, MAXC); end
    if (full !== 1'b1) begin mismatched++; $display("FAIL sat_full: got %b want 1", full); end
    if (total_rej !== 0) begin mismatched++; $display("FAIL sat_no_reject: got %0d want 0", total_rej); end
    press(0, 8, 8, rej);
    compared += 2;
    if (count !== 8'(MAXC)) begin mismatched++; $display("FAIL sat_hold: got %0d want %0d", count, MAXC); end
    if (rej !== 1) begin mismatched++; $display("FAIL sat_reject_cycles: got %0d want 1", rej); end
    press(1, 8, 8, rej);
    compared += 2;
    if (count !== 8'(MAXC - 1)) begin mismatched++; $display("FAIL sat_dec: got %0d want %0d", count, MAXC - 1); end
    if (full !== 1'b0) begin mismatched++; $display("FAIL sat_dec_full: got %b want 0", full); end
  endtask

  task automatic test_dec_at_zero();
    int rej;
    do_clear();
    press(1, 8, 8, rej);
    compared += 3;
    if (count !== 8'd0) begin mismatched++; $display("FAIL zero_count: got %0d want 0", count); end
    if (rej !== 1) begin mismatched++; $display("FAIL zero_reject_cycles: got %0d want 1", rej); end
    if (empty !== 1'b1) begin mismatched++; $display("FAIL zero_empty: got %b want 1", empty); end
  endtask

  task automatic test_simultaneous();
    int rej;
    int seq [12];
    do_clear();
    for (int p = 0; p < 40; p++) press(0, 8, 8, rej);
    compared++;
    if (count !== 8'd40) begin mismatched++; $display("FAIL simul_setup: got %0d want 40", count); end
    rej = 0;
    inc_raw = 1'b1;
    dec_raw = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (reject) rej++;
      compared++;
      if (count !== 8'd40) begin mismatched++; $display("FAIL simul_cancel edge %0d: count=%0d want 40", i + 1, count); end
    end
    inc_raw = 1'b0;
    dec_raw = 1'b0;
    repeat (8) begin tick(); if (reject) rej++; end
    compared++;
    if (rej !== 0) begin mismatched++; $display("FAIL simul_reject: got %0d want 0", rej); end
    inc_raw = 1'b1;
    tick();
    seq[0] = count;
    dec_raw = 1'b1;
    for (int i = 1; i < 12; i++) begin tick(); seq[i] = count; end
    compared += 3;
    if (seq[5] !== 40) begin mismatched++; $display("FAIL stagger_before: got %0d want 40", seq[5]); end
    if (seq[6] !== 41) begin mismatched++; $display("FAIL stagger_inc: got %0d want 41", seq[6]); end
    if (seq[7] !== 40) begin mismatched++; $display("FAIL stagger_dec: got %0d want 40", seq[7]); end
    inc_raw = 1'b0;
    dec_raw = 1'b0;
    repeat (10) tick();
  endtask

  task automatic test_clr_collision();
    int rej;
    do_clear();
    for (int p = 0; p < 25; p++) press(0, 8, 8, rej);
    compared++;
    if (count !== 8'd25) begin mismatched++; $display("FAIL clr_setup: got %0d want 25", count); end
    inc_raw = 1'b1;
    repeat (LAT - 1) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    compared += 2;
    if (count !== 8'd0) begin mismatched++; $display("FAIL clr_collision_count: got %0d want 0", count); end
    if (reject !== 1'b0) begin mismatched++; $display("FAIL clr_collision_reject: got %b want 0", reject); end
    repeat (5) tick();
    compared++;
    if (count !== 8'd0) begin mismatched++; $display("FAIL clr_collision_hold: got %0d want 0", count); end
    inc_raw = 1'b0;
    repeat (10) tick();
  endtask

  task automatic test_reset_mid();
    int rej;
    int exp;
    press(0, 8, 8, rej);
    inc_raw = 1'b1;
    repeat (3) tick();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    compared += 4;
    if (count !== 8'd0) begin mismatched++; $display("FAIL midrst_count: got %0d want 0", count); end
    if (full !== 1'b0) begin mismatched++; $display("FAIL midrst_full: got %b want 0", full); end
    if (empty !== 1'b1) begin mismatched++; $display("FAIL midrst_empty: got %b want 1", empty); end
    if (reject !== 1'b0) begin mismatched++; $display("FAIL midrst_reject: got %b want 0", reject); end
    repeat (2) tick();
    rst = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      exp = (i >= LAT) ? 1 : 0;
      compared++;
      if (count !== 8'(exp)) begin mismatched++; $display("FAIL midrst_press edge %0d: count=%0d want %0d", i, count, exp); end
    end
    inc_raw = 1'b0;
    repeat (10) tick();
  endtask

  task automatic test_random();
    int hold_i;
    int hold_d;
    hold_i = 0;
    hold_d = 0;
    for (int c = 0; c < 1500; c++) begin
      if (hold_i == 0) begin inc_raw = 1'($urandom_range(0, 1)); hold_i = $urandom_range(1, 12); end
      if (hold_d == 0) begin dec_raw = 1'($urandom_range(0, 1)); hold_d = $urandom_range(1, 12); end
      hold_i--;
      hold_d--;
      clr = ($urandom_range(0, 63) == 0);
      tick();
      compared += 4;
      if (count !== 8'(m_count)) begin mismatched++; $display("FAIL rand_count cyc %0d: got %0d want %0d", c, count, m_count); end
      if (reject !== m_reject) begin mismatched++; $display("FAIL rand_reject cyc %0d: got %b want %b", c, reject, m_reject); end
      if (full !== (m_count == MAXC)) begin mismatched++; $display("FAIL rand_full cyc %0d: got %b", c, full); end
      if (empty !== (m_count == 0)) begin mismatched++; $display("FAIL rand_empty cyc %0d: got %b", c, empty); end
    end
    clr = 1'b0;
    inc_raw = 1'b0;
    dec_raw = 1'b0;
    repeat (10) tick();
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst     = 1'b1;
    inc_raw = 1'b0;
    dec_raw = 1'b0;
    clr     = 1'b0;
    model_reset();
    test_reset();
    test_single_press();
    test_bounce();
    test_saturation();
    test_dec_at_zero();
    test_simultaneous();
    test_clr_collision();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
